// File: rtl/synabs_pkg.sv
// synabs_pkg: shared defaults, head-load select encoding and ring reset-value helper
// for the synabs_ring rotation block.
package synabs_pkg;
   localparam int WIDTH_DEF       = 5;
   localparam int DEPTH_DEF       = 3;
   localparam int INIT0_DEF       = 1;
   localparam int INIT_STRIDE_DEF = 4;
   localparam int T_INIT_DEF      = 11;
   localparam int STEP_DEF        = 2;
   localparam int MATCH_A_DEF     = 5;
   localparam int MATCH_B_DEF     = 1;
   localparam int LOAD_B_DEF      = 7;
   localparam int LOAD_C_DEF      = 3;
   localparam int BAD_DEF         = 2;
   localparam int CW_DEF          = 8;

   typedef enum logic [1:0] {SEL_A, SEL_B, SEL_C, SEL_T} sel_e;

   // Caller truncates to the ring width, giving the mod 2^WIDTH wrap.
   function automatic int ring_init(input int init0, input int stride, input int k);
      return init0 + k * stride;
   endfunction
endpackage

// File: rtl/synabs_ring_if.sv
// synabs_ring_if: control inputs and observation outputs of synabs_ring;
// the testbench side is the master, the ring is the slave.
interface synabs_ring_if #(
   parameter int WIDTH = 5,
   parameter int CW    = 8
) ();
   logic             i;
   logic             mode;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] t_out;
   logic             prop;
   logic             prop_neg;
   logic             viol_sticky;
   logic [CW-1:0]    first_viol_cycle;
   logic [CW-1:0]    cyc;

   modport master (output i, mode,
                   input  head, t_out, prop, prop_neg, viol_sticky, first_viol_cycle, cyc);
   modport slave  (input  i, mode,
                   output head, t_out, prop, prop_neg, viol_sticky, first_viol_cycle, cyc);
endinterface

// File: rtl/synabs_step_counter.sv
// synabs_step_counter: WIDTH-bit up/down counter moving by STEP when enabled,
// wrapping freely modulo 2^WIDTH.
module synabs_step_counter #(
   parameter int WIDTH  = 5,
   parameter int STEP   = 2,
   parameter int T_INIT = 11
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             en,
   input  logic             mode,
   output logic [WIDTH-1:0] t
);
   localparam logic [WIDTH-1:0] ST = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] TI = WIDTH'(T_INIT);

   logic [WIDTH-1:0] t_q, t_d;

   always_comb t_d = en ? (mode ? t_q - ST : t_q + ST) : t_q;

   always_ff @(posedge clock)
      t_q <= !reset_n ? TI : t_d;

   assign t = t_q;
endmodule

// File: rtl/synabs_ring.sv
// synabs_ring: DEPTH-deep rotating register ring with priority head load,
// stride counter and a sticky timestamped safety monitor on the head value.
module synabs_ring
   import synabs_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEF,
   parameter int DEPTH       = DEPTH_DEF,
   parameter int INIT0       = INIT0_DEF,
   parameter int INIT_STRIDE = INIT_STRIDE_DEF,
   parameter int T_INIT      = T_INIT_DEF,
   parameter int STEP        = STEP_DEF,
   parameter int MATCH_A     = MATCH_A_DEF,
   parameter int MATCH_B     = MATCH_B_DEF,
   parameter int LOAD_B      = LOAD_B_DEF,
   parameter int LOAD_C      = LOAD_C_DEF,
   parameter int BAD         = BAD_DEF,
   parameter int CW          = CW_DEF
) (
   input logic         clock,
   input logic         reset_n,
   synabs_ring_if.slave bus
);
   localparam logic [WIDTH-1:0] MA = WIDTH'(MATCH_A);
   localparam logic [WIDTH-1:0] MB = WIDTH'(MATCH_B);
   localparam logic [WIDTH-1:0] LB = WIDTH'(LOAD_B);
   localparam logic [WIDTH-1:0] LC = WIDTH'(LOAD_C);
   localparam logic [WIDTH-1:0] BD = WIDTH'(BAD);

   logic [WIDTH-1:0] r_q [DEPTH];
   logic [WIDTH-1:0] r_d [DEPTH];
   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] head_nxt;
   logic [CW-1:0]    cyc_q, cyc_d, fvc_q, fvc_d;
   logic             viol_q, viol_d;
   logic             prop;
   sel_e             sel;

   synabs_step_counter #(.WIDTH(WIDTH), .STEP(STEP), .T_INIT(T_INIT)) u_cnt (
      .clock  (clock),
      .reset_n(reset_n),
      .en     (bus.i),
      .mode   (bus.mode),
      .t      (t)
   );

   // With DEPTH=2 the tail is r[1], so SEL_C can never win over SEL_B.
   always_comb begin
      sel = (r_q[1] == MA) ? SEL_A :
            (r_q[DEPTH-1] == MB) ? SEL_B :
            (r_q[1] == MB) ? SEL_C : SEL_T;
      head_nxt = (sel == SEL_A) ? MA : (sel == SEL_B) ? LB : (sel == SEL_C) ? LC : t;
      for (int k = 0; k < DEPTH; k++) r_d[k] = r_q[k];
      if (bus.i) begin
         r_d[0] = head_nxt;
         for (int k = 1; k < DEPTH - 1; k++) r_d[k] = r_q[k+1];
         r_d[DEPTH-1] = r_q[0];
      end
      cyc_d  = (bus.i && cyc_q != '1) ? cyc_q + CW'(1) : cyc_q;
      prop   = r_q[0] != BD;
      viol_d = viol_q | ~prop;
      fvc_d  = (!prop && !viol_q) ? cyc_q : fvc_q;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) r_q[k] <= WIDTH'(ring_init(INIT0, INIT_STRIDE, k));
         cyc_q  <= '0;
         viol_q <= 1'b0;
         fvc_q  <= '0;
      end else begin
         r_q    <= r_d;
         cyc_q  <= cyc_d;
         viol_q <= viol_d;
         fvc_q  <= fvc_d;
      end
   end

   assign bus.head             = r_q[0];
   assign bus.t_out            = t;
   assign bus.prop             = prop;
   assign bus.prop_neg         = ~prop;
   assign bus.viol_sticky      = viol_q;
   assign bus.first_viol_cycle = fvc_q;
   assign bus.cyc              = cyc_q;
endmodule

// File: tb/tb_synabs_ring.sv
// tb_synabs_ring: directed vector table, hand sequences and a randomized run
// checked against an array-based model for three ring configurations.
module tb_synabs_ring;
   logic clock = 1'b0;
   logic rn = 1'b0, ii = 1'b0, md = 1'b0;
   int   passed = 0, total = 0;

   always #5 clock = ~clock;

   synabs_ring_if if0 ();
   synabs_ring_if if1 ();
   synabs_ring_if if2 ();
   assign if0.i = ii; assign if0.mode = md;
   assign if1.i = ii; assign if1.mode = md;
   assign if2.i = ii; assign if2.mode = md;

   synabs_ring                     u0 (.clock(clock), .reset_n(rn), .bus(if0));
   synabs_ring #(.BAD(19))         u1 (.clock(clock), .reset_n(rn), .bus(if1));
   synabs_ring #(.DEPTH(2))        u2 (.clock(clock), .reset_n(rn), .bus(if2));

   // model state per instance: ring as a plain array, rotated by index shifting
   localparam int MD [3] = '{3, 3, 2};
   localparam int MBAD [3] = '{2, 19, 2};
   int mr [3][16];
   int mt [3], mc [3], mf [3];
   bit mv [3];

   task automatic model_edge(input bit r_n, input bit en, input bit dn);
      for (int n = 0; n < 3; n++) begin
         if (!r_n) begin
            for (int k = 0; k < MD[n]; k++) mr[n][k] = (1 + 4 * k) % 32;
            mt[n] = 11; mc[n] = 0; mv[n] = 0; mf[n] = 0;
         end else begin
            int old [16];
            int d, h;
            if (mr[n][0] == MBAD[n] && !mv[n]) begin
               mv[n] = 1; mf[n] = mc[n];
            end
            if (en) begin
               d = MD[n];
               old = mr[n];
               if (old[1] == 5) h = 5;
               else if (old[d-1] == 1) h = 7;
               else if (old[1] == 1) h = 3;
               else h = mt[n];
               for (int k = 0; k < d - 1; k++) mr[n][k+1] = old[(k + 2) % d];
               mr[n][0] = h;
               mr[n][d-1] = old[0];
               mt[n] = (mt[n] + (dn ? 30 : 2)) % 32;
               mc[n] = (mc[n] < 255) ? mc[n] + 1 : 255;
            end
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      else passed++;
   endtask

   task automatic step(input bit r_n, input bit en, input bit dn);
      rn = r_n; ii = en; md = dn;
      @(posedge clock);
      model_edge(r_n, en, dn);
      #1;
   endtask

   task automatic chk_model(input int n, input int h, input int t, input int c,
                            input int v, input int f, input int p, input int pn);
      chk($sformatf("m%0d_head", n), h, mr[n][0]);
      chk($sformatf("m%0d_t", n), t, mt[n]);
      chk($sformatf("m%0d_cyc", n), c, mc[n]);
      chk($sformatf("m%0d_viol", n), v, int'(mv[n]));
      chk($sformatf("m%0d_fvc", n), f, mf[n]);
      chk($sformatf("m%0d_prop", n), p, int'(mr[n][0] != MBAD[n]));
      chk($sformatf("m%0d_propn", n), pn, int'(mr[n][0] == MBAD[n]));
   endtask

   task automatic chk_all();
      chk_model(0, if0.head, if0.t_out, if0.cyc, if0.viol_sticky, if0.first_viol_cycle, if0.prop, if0.prop_neg);
      chk_model(1, if1.head, if1.t_out, if1.cyc, if1.viol_sticky, if1.first_viol_cycle, if1.prop, if1.prop_neg);
      chk_model(2, if2.head, if2.t_out, if2.cyc, if2.viol_sticky, if2.first_viol_cycle, if2.prop, if2.prop_neg);
   endtask

   typedef struct {
      bit r_n; bit en; bit dn;
      int head; int t; int cyc; int h2;
   } vec_t;

   initial begin
      vec_t vt [$];
      // reset then five advances
      vt.push_back('{0,1,0, 1,11,0, 1});
      vt.push_back('{1,1,0, 5,13,1, 5});
      vt.push_back('{1,1,0, 7,15,2, 7});
      vt.push_back('{1,1,0, 3,17,3, 5});
      vt.push_back('{1,1,0, 5,19,4,17});
      vt.push_back('{1,1,0,19,21,5, 5});
      // hold after two advances, mode ignored while frozen
      vt.push_back('{0,0,0, 1,11,0, 1});
      vt.push_back('{1,1,0, 5,13,1, 5});
      vt.push_back('{1,1,0, 7,15,2, 7});
      vt.push_back('{1,0,1, 7,15,2, 7});
      vt.push_back('{1,0,0, 7,15,2, 7});
      vt.push_back('{1,0,1, 7,15,2, 7});
      vt.push_back('{1,1,0, 3,17,3, 5});
      // reset overriding an advancing down-count edge
      vt.push_back('{0,1,1, 1,11,0, 1});
      vt.push_back('{1,1,1, 5, 9,1, 5});
      vt.push_back('{1,1,1, 7, 7,2, 7});
      vt.push_back('{0,1,1, 1,11,0, 1});
      foreach (vt[j]) begin
         step(vt[j].r_n, vt[j].en, vt[j].dn);
         chk($sformatf("vec%0d_head", j), if0.head, vt[j].head);
         chk($sformatf("vec%0d_t", j), if0.t_out, vt[j].t);
         chk($sformatf("vec%0d_cyc", j), if0.cyc, vt[j].cyc);
         chk($sformatf("vec%0d_prop", j), if0.prop, 1);
         chk($sformatf("vec%0d_viol", j), if0.viol_sticky, 0);
         chk($sformatf("vec%0d_d2head", j), if2.head, vt[j].h2);
      end
      // counter wrap, both directions
      step(0, 0, 0);
      for (int k = 1; k <= 11; k++) begin
         step(1, 1, 0);
         chk($sformatf("wrap_up%0d", k), if0.t_out, (11 + 2 * k) % 32);
      end
      chk("wrap_up_final", if0.t_out, 1);
      step(0, 0, 0);
      for (int k = 1; k <= 6; k++) begin
         step(1, 1, 1);
         chk($sformatf("wrap_dn%0d", k), if0.t_out, (11 - 2 * k + 32) % 32);
      end
      chk("wrap_dn_final", if0.t_out, 31);
      // monitor with BAD=19
      step(0, 0, 0);
      for (int k = 1; k <= 5; k++) step(1, 1, 0);
      chk("bad_head", if1.head, 19);
      chk("bad_prop", if1.prop, 0);
      chk("bad_propn", if1.prop_neg, 1);
      chk("bad_viol_pre", if1.viol_sticky, 0);
      step(1, 1, 0);
      chk("bad_viol", if1.viol_sticky, 1);
      chk("bad_fvc", if1.first_viol_cycle, 5);
      for (int k = 0; k < 40; k++) step(1, 1, 0);
      chk("bad_viol_held", if1.viol_sticky, 1);
      chk("bad_fvc_held", if1.first_viol_cycle, 5);
      chk_all();
      // randomized run against the model
      step(0, 0, 0);
      chk_all();
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
         chk_all();
      end
      // saturation of the cycle counter
      step(0, 0, 0);
      for (int k = 0; k < 300; k++) step(1, 1, 1'($urandom_range(0, 1)));
      chk("cyc_sat", if0.cyc, 255);
      chk_all();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
